// File: rtl/kws_pkg.sv
// Shared types and defaults for the keyword-spotting pipeline
// (fully_connected -> fc_argmax).
package kws_pkg;

    localparam int unsigned NUM_CLASSES = 8;
    localparam int unsigned DATA_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } fc_argmax_state_t;

endpackage

// File: rtl/argmax_cmp.sv
// Registered signed compare-and-select of the running (best, best_idx)
// against one candidate element per cycle.
module argmax_cmp #(
    parameter int unsigned DATA_WIDTH = kws_pkg::DATA_WIDTH,
    parameter int unsigned IDX_W      = $clog2(kws_pkg::NUM_CLASSES)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] elem,
    input  logic        [IDX_W-1:0]      elem_idx,
    output logic signed [DATA_WIDTH-1:0] sel_score_c,
    output logic        [IDX_W-1:0]      sel_idx_c
);

    logic signed [DATA_WIDTH-1:0] best;
    logic        [IDX_W-1:0]      best_idx;
    logic                         gt_c;

    // Strictly greater keeps the earlier index on ties.
    always_comb begin
        gt_c        = elem > best;
        sel_score_c = gt_c ? elem     : best;
        sel_idx_c   = gt_c ? elem_idx : best_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best     <= '0;
            best_idx <= '0;
        end else if (load) begin
            best     <= elem;
            best_idx <= elem_idx;
        end else if (en) begin
            best     <= sel_score_c;
            best_idx <= sel_idx_c;
        end
    end

endmodule

// File: rtl/fc_argmax.sv
// Sequential argmax over the fully_connected logit vector, one element per cycle.
// Optional confidence threshold enabled by defining FC_ARGMAX_THRESHOLD_EN.
module fc_argmax #(
    parameter int unsigned NUM_CLASSES = kws_pkg::NUM_CLASSES,
    parameter int unsigned DATA_WIDTH  = kws_pkg::DATA_WIDTH,
    parameter int unsigned INPUT_SIZE  = NUM_CLASSES * DATA_WIDTH,
    parameter logic signed [DATA_WIDTH-1:0] THRESHOLD = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [INPUT_SIZE-1:0]          data_in,
    input  logic                           data_valid,
    output logic                           busy,
    output logic [$clog2(NUM_CLASSES)-1:0] class_idx,
    output logic [DATA_WIDTH-1:0]          class_score,
    output logic                           class_unknown,
    output logic                           class_valid,
    output logic                           overrun
);

    import kws_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_CLASSES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);

    fc_argmax_state_t state, state_nxt;

    logic [INPUT_SIZE-1:0]        data_q;
    logic [IDX_W-1:0]             cnt;
    logic [IDX_W-1:0]             cmp_idx;
    logic [IDX_W-1:0]             sel_idx_c;
    logic signed [DATA_WIDTH-1:0] elem_sel;
    logic signed [DATA_WIDTH-1:0] cmp_elem;
    logic signed [DATA_WIDTH-1:0] sel_score_c;
    logic capture, scan_en, last, result_ld, busy_d, valid_d;

    assign elem_sel = data_q[int'(cnt) * DATA_WIDTH +: DATA_WIDTH];

    // Element 0 is loaded straight from the input bus on the capture edge.
    assign cmp_elem = capture ? data_in[DATA_WIDTH-1:0] : elem_sel;
    assign cmp_idx  = capture ? '0 : cnt;

    argmax_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_cmp (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (capture),
        .en          (scan_en),
        .elem        (cmp_elem),
        .elem_idx    (cmp_idx),
        .sel_score_c (sel_score_c),
        .sel_idx_c   (sel_idx_c)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (data_valid) state_nxt = SCAN;
            SCAN:    if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        capture   = 1'b0;
        scan_en   = 1'b0;
        last      = 1'b0;
        result_ld = 1'b0;
        busy_d    = 1'b0;
        valid_d   = 1'b0;
        capture   = (state == IDLE) && data_valid;
        scan_en   = (state == SCAN);
        last      = (cnt == LAST);
        result_ld = scan_en && last;
        busy_d    = (state_nxt != IDLE);
        valid_d   = (state_nxt == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            data_q      <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            class_valid <= 1'b0;
            class_idx   <= '0;
            class_score <= '0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nxt;
            busy        <= busy_d;
            class_valid <= valid_d;
            if (capture) begin
                data_q <= data_in;
                cnt    <= IDX_W'(1);
            end else if (scan_en && !last) begin
                cnt <= cnt + IDX_W'(1);
            end
            if (result_ld) begin
                class_idx   <= sel_idx_c;
                class_score <= sel_score_c;
            end
            // Vectors offered while busy are dropped and flagged until reset.
            if (data_valid && (state != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef FC_ARGMAX_THRESHOLD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            class_unknown <= 1'b0;
        end else if (result_ld) begin
            class_unknown <= (sel_score_c < THRESHOLD);
        end
    end
`else
    assign class_unknown = 1'b0;
`endif

endmodule

// File: tb/tb_fc_argmax.sv
// Scoreboard bench for fc_argmax: expected results are queued at stimulus time
// and compared when class_valid pulses.
`timescale 1ns/1ps
module tb_fc_argmax;

    localparam int unsigned NC = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned IW = 3;
    localparam int unsigned IS = NC * DW;
`ifdef FC_ARGMAX_THRESHOLD_EN
    localparam logic signed [DW-1:0] THR = 16'sd10;
`else
    localparam logic signed [DW-1:0] THR = 16'sd0;
`endif

    typedef logic signed [DW-1:0] lg_t;
    typedef lg_t vec_t [NC];
    typedef struct {
        logic [IW-1:0] idx;
        lg_t           score;
        logic          unk;
        int            cyc;
        string         name;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [IS-1:0] data_in;
    logic          data_valid;
    logic          busy;
    logic [IW-1:0] class_idx;
    logic [DW-1:0] class_score;
    logic          class_unknown;
    logic          class_valid;
    logic          overrun;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pop    = 0;
    int   cyc      = 0;

    fc_argmax #(
        .NUM_CLASSES (NC),
        .DATA_WIDTH  (DW),
        .INPUT_SIZE  (IS),
        .THRESHOLD   (THR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .busy          (busy),
        .class_idx     (class_idx),
        .class_score   (class_score),
        .class_unknown (class_unknown),
        .class_valid   (class_valid),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [IS-1:0] pack(input vec_t v);
        logic [IS-1:0] p;
        p = '0;
        for (int i = 0; i < NC; i++) p[i*DW +: DW] = v[i];
        return p;
    endfunction

    function automatic exp_t model(input vec_t v, input string name, input int c);
        exp_t e;
        e.score = v[0];
        e.idx   = '0;
        for (int i = 1; i < NC; i++) begin
            if (v[i] > e.score) begin
                e.score = v[i];
                e.idx   = IW'(i);
            end
        end
`ifdef FC_ARGMAX_THRESHOLD_EN
        e.unk = (e.score < THR);
`else
        e.unk = 1'b0;
`endif
        e.cyc  = c;
        e.name = name;
        return e;
    endfunction

    // Scoreboard consumer: every class_valid must match the oldest queued result.
    always @(negedge clk) begin
        if (rst_n && class_valid) begin
            exp_t e;
            n_pop++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_class_valid cycle=%0d idx=%0d score=%0d", cyc, class_idx, $signed(class_score));
            end else begin
                e = sb.pop_front();
                if (class_idx !== e.idx || class_score !== e.score || class_unknown !== e.unk || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL result_%s got idx=%0d score=%0d unk=%0b cyc=%0d expected idx=%0d score=%0d unk=%0b cyc=%0d",
                             e.name, class_idx, $signed(class_score), class_unknown, cyc,
                             e.idx, e.score, e.unk, e.cyc);
                end
            end
        end
    end

    // Drives one single-cycle data_valid pulse; returns at the negedge after the capture edge.
    task automatic drive_vec(input vec_t v, input string name, input bit expect_cap);
        @(negedge clk);
        data_in    = pack(v);
        data_valid = 1'b1;
        if (expect_cap) sb.push_back(model(v, name, cyc + NC));
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || sb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 200) begin
            n_fail++;
            $display("FAIL timeout_%s busy=%0b pending=%0d expected idle with 0 pending", name, busy, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;
        #12;
        n_checks++;
        if ({busy, class_idx, class_score, class_unknown, class_valid, overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got busy=%0b idx=%0d score=%0h unk=%0b valid=%0b ovr=%0b expected all 0",
                     busy, class_idx, class_score, class_unknown, class_valid, overrun);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || class_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle got busy=%0b valid=%0b expected 0 0", busy, class_valid);
        end
    endtask

    task automatic test_basic();
        vec_t v = '{16'sd3, -16'sd5, 16'sd12, 16'sd7, 16'sd12, -16'sd1, 16'sd0, 16'sd4};
        int   bcnt = 0;
        drive_vec(v, "basic", 1'b1);
        if (busy) bcnt++;
        repeat (11) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
        n_checks++;
        if (bcnt != 8) begin
            n_fail++;
            $display("FAIL basic_busy_cycles got %0d expected 8", bcnt);
        end
        n_checks++;
        if (class_idx !== 3'd2) begin
            n_fail++;
            $display("FAIL basic_idx got %0d expected 2", class_idx);
        end
        n_checks++;
        if (class_score !== 16'd12) begin
            n_fail++;
            $display("FAIL basic_score got %0h expected 000c", class_score);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL basic_pending got %0d expected 0", sb.size());
        end
    endtask

    task automatic test_all_negative();
        vec_t v = '{-16'sd9, -16'sd3, -16'sd20, -16'sd3, -16'sd8, -16'sd100, -16'sd7, -16'sd4};
        drive_vec(v, "all_neg", 1'b1);
        wait_idle("all_neg");
        n_checks++;
        if (class_idx !== 3'd1 || class_score !== 16'hFFFD) begin
            n_fail++;
            $display("FAIL all_neg got idx=%0d score=%0h expected idx=1 score=fffd", class_idx, class_score);
        end
    endtask

    task automatic test_threshold();
        vec_t v1 = '{16'sd3, -16'sd5, 16'sd12, 16'sd7, 16'sd12, -16'sd1, 16'sd0, 16'sd4};
        vec_t v2 = '{16'sd1, 16'sd2, 16'sd3, -16'sd4, 16'sd5, 16'sd0, 16'sd9, 16'sd8};
        logic exp_unk2;
`ifdef FC_ARGMAX_THRESHOLD_EN
        exp_unk2 = 1'b1;
`else
        exp_unk2 = 1'b0;
`endif
        drive_vec(v1, "thr_hi", 1'b1);
        wait_idle("thr_hi");
        n_checks++;
        if (class_unknown !== 1'b0) begin
            n_fail++;
            $display("FAIL thr_hi_unknown got %0b expected 0", class_unknown);
        end
        drive_vec(v2, "thr_lo", 1'b1);
        wait_idle("thr_lo");
        n_checks++;
        if (class_idx !== 3'd6 || class_score !== 16'd9 || class_unknown !== exp_unk2) begin
            n_fail++;
            $display("FAIL thr_lo got idx=%0d score=%0d unk=%0b expected idx=6 score=9 unk=%0b",
                     class_idx, $signed(class_score), class_unknown, exp_unk2);
        end
    endtask

    task automatic test_overrun();
        vec_t v  = '{16'sd5, 16'sd50, -16'sd2, 16'sd49, 16'sd0, 16'sd50, 16'sd1, -16'sd60};
        vec_t v2 = '{16'sd99, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        drive_vec(v, "overrun_first", 1'b1);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_early got %0b expected 0", overrun);
        end
        data_in    = pack(v2);
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_rise got %0b expected 1", overrun);
        end
        wait_idle("overrun");
        repeat (15) @(negedge clk);
        n_checks++;
        if (class_idx !== 3'd1 || class_score !== 16'd50) begin
            n_fail++;
            $display("FAIL overrun_result got idx=%0d score=%0d expected idx=1 score=50", class_idx, $signed(class_score));
        end
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky got %0b expected 1", overrun);
        end
    endtask

    task automatic test_back_to_back();
        int mb   = 0;
        int caps = 0;
        int pop0 = n_pop;
        for (int k = 0; k < 30; k++) begin
            vec_t v;
            for (int i = 0; i < NC; i++) v[i] = lg_t'($urandom_range(0, 65535));
            data_in    = pack(v);
            data_valid = 1'b1;
            if (mb == 0) begin
                sb.push_back(model(v, $sformatf("b2b%0d", k), cyc + NC));
                caps++;
                mb = NC;
            end else begin
                mb--;
            end
            @(negedge clk);
        end
        data_valid = 1'b0;
        wait_idle("b2b");
        n_checks++;
        if (n_pop - pop0 != caps) begin
            n_fail++;
            $display("FAIL b2b_result_count got %0d expected %0d", n_pop - pop0, caps);
        end
    endtask

    task automatic test_reset_mid_scan();
        vec_t v  = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd8};
        vec_t v2 = '{-16'sd1, 16'sd30, 16'sd30, 16'sd2, 16'sd31, 16'sd0, -16'sd31, 16'sd3};
        int pop0;
        drive_vec(v, "rst_mid", 1'b0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_busy_before got %0b expected 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, class_idx, class_score, class_unknown, class_valid, overrun} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs got busy=%0b idx=%0d score=%0h unk=%0b valid=%0b ovr=%0b expected all 0",
                     busy, class_idx, class_score, class_unknown, class_valid, overrun);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pop0  = n_pop;
        repeat (12) @(negedge clk);
        n_checks++;
        if (n_pop != pop0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_no_result got pulses=%0d busy=%0b expected 0 0", n_pop - pop0, busy);
        end
        drive_vec(v2, "rst_mid_after", 1'b1);
        wait_idle("rst_mid_after");
        n_checks++;
        if (class_idx !== 3'd4 || class_score !== 16'd31) begin
            n_fail++;
            $display("FAIL rst_mid_after got idx=%0d score=%0d expected idx=4 score=31", class_idx, $signed(class_score));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_all_negative();
        test_threshold();
        test_overrun();
        test_back_to_back();
        test_reset_mid_scan();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL final_pending got %0d expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fc_argmax.md
# fc_argmax

Classification stage directly downstream of `fully_connected`. It takes the packed logit vector that `fully_connected` produces on `data_out`/`data_out_valid` and scans the elements sequentially, one per cycle. It reports the index and score of the largest signed logit, which is the keyword decision of the network. An optional confidence threshold flags low-score results as unknown.

## Interface
- `NUM_CLASSES`, default 8: number of logits; must be ≥ 2.
- `DATA_WIDTH`, default 16: width of each logit, signed two's complement.
- `INPUT_SIZE`, default `NUM_CLASSES*DATA_WIDTH` (128): width of `data_in`; must equal the `fully_connected` `OUTPUT_SIZE`.
- `THRESHOLD`, default 0: signed `DATA_WIDTH` confidence threshold; used only when `FC_ARGMAX_THRESHOLD_EN` is defined.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  `INPUT_SIZE`  packed logits; element i is `data_in[i*DATA_WIDTH +: DATA_WIDTH]`.
- `data_valid`  in  1  the vector on `data_in` is valid this cycle; connects to `fully_connected.data_out_valid`.
- `busy`  out  1  a scan is in progress; `data_valid` is ignored while high.
- `class_idx`  out  `$clog2(NUM_CLASSES)`  index of the winning logit.
- `class_score`  out  `DATA_WIDTH`  value of the winning logit.
- `class_unknown`  out  1  the winning score is below `THRESHOLD`.
- `class_valid`  out  1  one-cycle pulse; `class_*` are valid.
- `overrun`  out  1  sticky flag: a `data_valid` arrived while `busy` was high.

## Operation
- FSM has three states: IDLE, SCAN, DONE. `busy` = (state ≠ IDLE).
- **IDLE:** on `data_valid`=1, register the whole `data_in`. Set best ← element 0, best_idx ← 0, cnt ← 1. Go to SCAN.
- **SCAN:** each cycle, compare element[cnt] against best, using a signed comparison. Update best and best_idx only when element[cnt] > best (strictly greater), so ties resolve to the lowest index.
  - When cnt == NUM_CLASSES−1: register the final result into `class_idx`, `class_score` and `class_unknown`, then go to DONE.
  - Otherwise cnt ← cnt+1.
- **DONE:** `class_valid`=1 for exactly this one cycle, then go to IDLE. `data_valid` is not accepted in DONE.
- `class_idx` and `class_score` hold their last value until the next result is registered.
- **Overrun:** `data_valid`=1 while in SCAN or DONE sets `overrun`=1. The vector is dropped and the scan in progress is unaffected. Only reset clears `overrun`.
- **Reset:**
  - Asynchronous assertion at any time, including mid-scan, forces IDLE.
  - All outputs go to 0 (`busy`, `class_idx`, `class_score`, `class_unknown`, `class_valid`, `overrun`). cnt goes to 0.
  - No partial result is ever emitted.
- Comparison and all storage are `DATA_WIDTH` bits wide; there is no arithmetic growth.

## Timing
- Capture edge E0 (IDLE with `data_valid`=1). `busy` is high from the cycle after E0.
- Result is registered at edge E(NUM_CLASSES−1).
- `class_valid` is high during the cycle after E(NUM_CLASSES−1). With the defaults that is the 7th cycle after capture.
- The FSM returns to IDLE at edge E(NUM_CLASSES). The earliest next capture is at E(NUM_CLASSES+1).
- Throughput is one vector per NUM_CLASSES+1 cycles.
- `busy` falls in the same cycle that IDLE is re-entered.

## Configuration
- The macro is `FC_ARGMAX_THRESHOLD_EN`.
- **Defined:**
  - `class_unknown` is registered alongside `class_idx` and equals (best < `THRESHOLD`), signed.
  - `class_idx` and `class_score` still report the argmax.
- **Undefined:**
  - No comparator is built and `THRESHOLD` is unused.
  - `class_unknown` is constant 0.
  - The port list is identical in both builds.

## Structure
- The shared package `kws_pkg` holds:
  - the `fc_argmax_state_t` enum (IDLE, SCAN, DONE);
  - the default `NUM_CLASSES` and `DATA_WIDTH` localparams, which `fully_connected` also uses.
- One sub-module, `argmax_cmp`: a registered signed compare-and-select of (best, best_idx) against (element, cnt). It has an enable input and a load-initial input.
- Element selection from the captured vector uses an indexed part-select on cnt; there is no extra sub-module for it.

## Test plan
- **Basic:**
  - Stimulus: defaults; logits 0..7 = {3, −5, 12, 7, 12, −1, 0, 4}; one `data_valid` pulse.
  - Required: `class_valid` exactly 7 cycles after capture; `class_idx`=2 (tie with element 4 goes to the lower index); `class_score`=12; `busy` high for 8 cycles.
- **All negative:**
  - Stimulus: logits {−9, −3, −20, −3, −8, −100, −7, −4}.
  - Required: `class_idx`=1, `class_score`=−3 (0xFFFD).
- **Threshold (macro defined, `THRESHOLD`=10):**
  - Stimulus: the basic-case vector, then a vector with max 9 at index 6.
  - Required: `class_unknown`=0 for the first result, then `class_unknown`=1 with `class_idx`=6.
  - With the macro undefined: `class_unknown` stays 0 for both.
- **Overrun:**
  - Stimulus: a second `data_valid` 3 cycles after capture.
  - Required: `overrun` rises in the next cycle; the first result is unchanged; no second `class_valid`; `overrun` stays high until `rst_n`=0.
- **Back-to-back:**
  - Stimulus: `data_valid` held high continuously with a new vector every cycle.
  - Required: captures occur 9 cycles apart; each result matches the vector present at its capture edge.
- **Reset mid-scan:**
  - Stimulus: `rst_n`=0 asynchronously 4 cycles after capture.
  - Required: all outputs 0 immediately; no `class_valid` after release; a new capture after release gives the correct result.
